// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM states, operand-family grouping and the most-negative-value helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam int MDU_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } mdu_state_t;

    // Most negative two's-complement value of width w, zero-extended to MDU_MAX_W.
    function automatic logic [MDU_MAX_W-1:0] mdu_min_val(input int w);
        return {{(MDU_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

    // Ops sharing one computation: a cached result of one member answers the others.
    function automatic logic [2:0] mdu_family(input logic [2:0] o);
        case (o)
            MDU_DIV, MDU_REM:   return 3'd0;
            MDU_DIVU, MDU_REMU: return 3'd1;
            MDU_MUL, MDU_MULH:  return 3'd2;
            MDU_MULHSU:         return 3'd3;
            default:            return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation; passes the input through when en=0.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M-style multiply/divide unit: one result bit per cycle.
// Optional result cache enabled by defining MDU_RESULT_CACHE_EN.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(mdu_min_val(WIDTH));

    mdu_state_t         state;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [CNT_W-1:0]   cnt;
    logic               neg_p, neg_q, neg_r;

    logic               a_sgn, b_sgn, sa, sb, is_mul, div0, ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, rem_sh, trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;
    logic               cache_hit;
    logic [WIDTH-1:0]   hit_hi, hit_lo;

    function automatic logic [WIDTH-1:0] sel_result(input logic [2:0] o,
                                                    input logic [WIDTH-1:0] hi,
                                                    input logic [WIDTH-1:0] lo);
        case (o)
            MDU_MUL, MDU_DIV, MDU_DIVU: return lo;
            default:                    return hi;
        endcase
    endfunction

    assign a_sgn  = (op_r == MDU_MUL) || (op_r == MDU_MULH) || (op_r == MDU_MULHSU) ||
                    (op_r == MDU_DIV) || (op_r == MDU_REM);
    assign b_sgn  = (op_r == MDU_MUL) || (op_r == MDU_MULH) ||
                    (op_r == MDU_DIV) || (op_r == MDU_REM);
    assign sa     = a_sgn & a_r[WIDTH-1];
    assign sb     = b_sgn & b_r[WIDTH-1];
    assign is_mul = ~op_r[2];
    assign div0   = op_r[2] && (b_r == '0);
    assign ovf    = op_r[2] && !op_r[0] && (a_r == MIN_VAL) && (b_r == '1);

    mdu_negate #(.W(WIDTH)) u_mag_a (.din(a_r), .en(sa), .dout(mag_a));
    mdu_negate #(.W(WIDTH)) u_mag_b (.din(b_r), .en(sb), .dout(mag_b));

    // Shift-add product step and restoring-divide trial subtraction.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : '0)};
    assign rem_sh  = {rem, acc[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, mag_b};

    mdu_negate #(.W(2*WIDTH)) u_fix_p (.din(acc), .en(neg_p), .dout(prod_fix));
    mdu_negate #(.W(WIDTH))   u_fix_q (.din(acc[WIDTH-1:0]), .en(neg_q), .dout(q_fix));
    mdu_negate #(.W(WIDTH))   u_fix_r (.din(rem), .en(neg_r), .dout(r_fix));

    assign fix_hi = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : r_fix;
    assign fix_lo = is_mul ? prod_fix[WIDTH-1:0]       : q_fix;

`ifdef MDU_RESULT_CACHE_EN
    logic             c_vld;
    logic [WIDTH-1:0] c_a, c_b, c_hi, c_lo;
    logic [2:0]       c_fam;

    assign cache_hit = c_vld && (a == c_a) && (b == c_b) && (mdu_family(op) == c_fam);
    assign hit_hi    = c_hi;
    assign hit_lo    = c_lo;

    // Only operations that reach FIX unflushed refresh the cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld <= 1'b0;
            c_a   <= '0;
            c_b   <= '0;
            c_hi  <= '0;
            c_lo  <= '0;
            c_fam <= '0;
        end else if (state == FIX && !flush) begin
            c_vld <= 1'b1;
            c_a   <= a_r;
            c_b   <= b_r;
            c_hi  <= fix_hi;
            c_lo  <= fix_lo;
            c_fam <= mdu_family(op_r);
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_hi    = '0;
    assign hit_lo    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            neg_p  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        if (cache_hit) begin
                            // Preload both halves unsigned so FIX just selects.
                            acc   <= {hit_hi, hit_lo};
                            rem   <= hit_hi;
                            neg_p <= 1'b0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end else begin
                            busy  <= 1'b1;
                            state <= PREP;
                        end
                    end
                end
                PREP: begin
                    cnt <= '0;
                    if (div0) begin
                        acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                        rem   <= a_r;
                        neg_p <= 1'b0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= FIX;
                    end else if (ovf) begin
                        acc   <= {{WIDTH{1'b0}}, MIN_VAL};
                        rem   <= '0;
                        neg_p <= 1'b0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        state <= FIX;
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, mag_a};
                        rem   <= '0;
                        neg_p <= sa ^ sb;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (is_mul) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    result <= sel_result(op_r, fix_hi, fix_lo);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter (WIDTH=32); latencies are counted in
// rising edges after the accepting edge.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef MDU_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int LAT_N  = 34;
    localparam int LAT_SP = 2;
    localparam int LAT_RN = CACHE ? 1 : 34;
    localparam int LAT_RS = CACHE ? 1 : 2;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issues one op and waits for done; no checking here.
    task automatic issue_and_wait(input bit now, input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output int lat,
                                  output logic [31:0] res, output bit busy_ok);
        if (!now) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; res = 'x; busy_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; res = result;
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #3;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mul;
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
        logic [31:0] xa  [5] = '{32'd7, 32'd7, 32'd7, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] xb  [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] exp [5] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFFF, 32'h40000000};
        int          el  [5];
        int lat; logic [31:0] res; bit bok;
        el = '{LAT_N, LAT_RN, LAT_N, LAT_N, LAT_N};
        for (int i = 0; i < 5; i++) begin
            issue_and_wait(1'b0, ops[i], xa[i], xb[i], lat, res, bok);
            n_vec++; if (res !== exp[i]) begin n_fail++; $display("FAIL mul%0d_result got %h want %h", i, res, exp[i]); end
            n_vec++; if (lat != el[i]) begin n_fail++; $display("FAIL mul%0d_latency got %0d want %0d", i, lat, el[i]); end
            n_vec++; if (!bok) begin n_fail++; $display("FAIL mul%0d_busy got bad busy want high until done", i); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] xa  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] xb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int          el  [4];
        int lat; logic [31:0] res; bit bok;
        el = '{LAT_N, LAT_RN, LAT_N, LAT_RN};
        for (int i = 0; i < 4; i++) begin
            issue_and_wait(1'b0, ops[i], xa[i], xb[i], lat, res, bok);
            n_vec++; if (res !== exp[i]) begin n_fail++; $display("FAIL div%0d_result got %h want %h", i, res, exp[i]); end
            n_vec++; if (lat != el[i]) begin n_fail++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, el[i]); end
        end
    endtask

    task automatic test_special;
        logic [2:0]  ops [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] xa  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] xb  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int          el  [4];
        int lat; logic [31:0] res; bit bok;
        el = '{LAT_SP, LAT_SP, LAT_SP, LAT_RS};
        for (int i = 0; i < 4; i++) begin
            issue_and_wait(1'b0, ops[i], xa[i], xb[i], lat, res, bok);
            n_vec++; if (res !== exp[i]) begin n_fail++; $display("FAIL spec%0d_result got %h want %h", i, res, exp[i]); end
            n_vec++; if (lat != el[i]) begin n_fail++; $display("FAIL spec%0d_latency got %0d want %0d", i, lat, el[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] res; bit bok;
        issue_and_wait(1'b0, 3'd0, 32'd3, 32'd5, lat, res, bok);
        n_vec++; if (res !== 32'd15) begin n_fail++; $display("FAIL b2b_first got %h want %h", res, 32'd15); end
        issue_and_wait(1'b1, 3'd0, 32'd6, 32'd7, lat, res, bok);
        n_vec++; if (res !== 32'd42) begin n_fail++; $display("FAIL b2b_second got %h want %h", res, 32'd42); end
        n_vec++; if (lat != LAT_N) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_N); end
        n_vec++; if (!bok) begin n_fail++; $display("FAIL b2b_busy got bad busy want high until done"); end
    endtask

    task automatic test_start_while_busy;
        int pulses = 0; int lat = -1; logic [31:0] res = 'x;
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; lat = k; res = result; end
            if (k == 5) begin start = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0; end
            if (k == 6) start = 1'b0;
        end
        n_vec++; if (pulses != 1) begin n_fail++; $display("FAIL swb_pulses got %0d want 1", pulses); end
        n_vec++; if (res !== 32'd6) begin n_fail++; $display("FAIL swb_result got %h want %h", res, 32'd6); end
        n_vec++; if (lat != LAT_N) begin n_fail++; $display("FAIL swb_latency got %0d want %0d", lat, LAT_N); end
    endtask

    task automatic test_start_flush;
        int pulses = 0;
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd4; b = 32'd4;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sf_busy got %b want 0", busy); end
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) pulses++; end
        n_vec++; if (pulses != 0) begin n_fail++; $display("FAIL sf_done got %0d pulses want 0", pulses); end
        n_vec++; if (result !== 32'd6) begin n_fail++; $display("FAIL sf_result got %h want %h", result, 32'd6); end
    endtask

    task automatic test_flush;
        int pulses = 0;
        @(negedge clk); start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", done); end
        n_vec++; if (result !== 32'd6) begin n_fail++; $display("FAIL flush_result got %h want %h", result, 32'd6); end
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) pulses++; end
        n_vec++; if (pulses != 0) begin n_fail++; $display("FAIL flush_late_done got %0d pulses want 0", pulses); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        @(negedge clk); start = 1'b1; op = 3'd4; a = 32'd50; b = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
        n_vec++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", result); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) pulses++; end
        n_vec++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_done_later got %0d pulses want 0", pulses); end
    endtask

`ifdef MDU_RESULT_CACHE_EN
    task automatic test_cache;
        int lat; logic [31:0] res; bit bok;
        issue_and_wait(1'b0, 3'd4, 32'd100, 32'd7, lat, res, bok);
        n_vec++; if (res !== 32'd14) begin n_fail++; $display("FAIL cache_div got %h want %h", res, 32'd14); end
        n_vec++; if (lat != LAT_N) begin n_fail++; $display("FAIL cache_div_latency got %0d want %0d", lat, LAT_N); end
        issue_and_wait(1'b0, 3'd6, 32'd100, 32'd7, lat, res, bok);
        n_vec++; if (res !== 32'd2) begin n_fail++; $display("FAIL cache_rem got %h want %h", res, 32'd2); end
        n_vec++; if (lat != 1) begin n_fail++; $display("FAIL cache_rem_latency got %0d want 1", lat); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cache_busy got %b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_back_to_back;
        test_start_while_busy;
        test_start_flush;
        test_flush;
        test_reset_mid;
`ifdef MDU_RESULT_CACHE_EN
        test_cache;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit implementing the RV32M operations, generalised to WIDTH bits.
- Sits in EX beside the combinational ALU; the pipeline stalls on busy.
- Start/busy/done handshake; one result bit per cycle via shift-add (multiply) or restoring (divide) iteration.
- Fast path for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  in  WIDTH  rs1 operand, sampled on accepted start
- b  in  WIDTH  rs2 operand, sampled on accepted start
- flush  in  1  abort any operation in flight
- busy  out  1  high from the cycle after accept until the done cycle (inclusive of the done cycle: no)
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  registered; holds last value until the next done

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal registers cleared; any operation in progress is lost, with no done.
- States:
  - IDLE: start=1 latches op, a, b and goes to PREP; start=0 stays in IDLE.
  - PREP (1 cycle):
    - Forms magnitudes |a|, |b| per op signedness: MUL/MULH/DIV/REM signed both; MULHSU signed a only; others unsigned.
    - Records result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
    - Special cases go straight to FIX with a preset result:
      - Divide by zero (b=0): DIV/DIVU give all-ones; REM/REMU give a.
      - Signed overflow (DIV/REM with a=MIN, b=-1): DIV gives MIN; REM gives 0.
    - Otherwise clears the counter and goes to ITER.
  - ITER (exactly WIDTH cycles):
    - Multiply: 2*WIDTH accumulator, add-and-shift on multiplier LSB.
    - Divide: shift remainder/quotient left, trial-subtract, set quotient bit if non-negative.
    - When counter reaches WIDTH-1, go to FIX.
  - FIX (1 cycle):
    - Conditionally two's-complement negate the 2W product or the quotient/remainder.
    - Select low half (MUL), high half (MULH*), quotient, or remainder.
    - Register the selection into result; done=1; return to IDLE.
- Latency, with accept at edge 0:
  - Normal ops: done at edge WIDTH+2 (34 for WIDTH=32).
  - Special cases: done at edge 2.
  - busy=1 on edges 1 through the done edge minus 1, and 0 on the done edge, so back-to-back start is allowed in the done cycle.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - done never coincides with busy=1.
- Flush:
  - Any state returns to IDLE next edge, with busy=0 and no done.
  - result keeps its old value.
  - flush and start in the same cycle: flush wins, start is dropped.
- Width rules:
  - MULH* returns product bits [2W-1:W].
  - The magnitude of MIN is representable as an unsigned W-bit value; no extension is needed beyond 1 guard bit in the divide remainder (W+1 bits).

Optional Feature:
- Macro MDU_RESULT_CACHE_EN.
- When defined:
  - Store the last completed a, b, family and both halves: quotient+remainder for div, or full 2W product for mul.
  - A new accepted start with identical a, b and the same family gives a cache hit:
    - Families: {DIV,REM}, {DIVU,REMU}, {MUL,MULH}, {MULHSU}, {MULHU}.
    - Skip PREP/ITER; done at edge 1; busy stays 0.
  - Cache valid clears on reset only; it is updated only on completed (non-flushed) operations.
- When undefined: no cache storage; every op takes the normal latency.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MUL..MDU_REMU (3-bit);
  - state enum IDLE/PREP/ITER/FIX;
  - helper localparam for MIN value per WIDTH.
- One sub-module, mdu_negate: parametrised conditional two's-complement (input, enable -> output). It is instanced for operand magnitudes and result fix-up.

Test Plan:
- MUL a=7, b=-3 -> done at edge 34, result=0xFFFFFFEB; MULH same -> 0xFFFFFFFF; MULHU -> 0x00000006.
- MULHSU a=-1 (0xFFFFFFFF), b=0xFFFFFFFF -> result=0xFFFFFFFF; MULH a=0x80000000, b=0x80000000 -> 0x40000000.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- Divide by zero:
  - DIV a=5, b=0 -> 0xFFFFFFFF at edge 2; REMU a=5, b=0 -> 5.
  - DIV 0x80000000 / -1 -> 0x80000000; REM -> 0.
- Flush and start rules:
  - flush at edge 10 of a DIV -> busy=0 at edge 11, no done, result unchanged.
  - start while busy -> ignored.
  - start+flush in the same cycle -> no accept.
- Reset mid-operation:
  - rst_n low at edge 5, asynchronously -> busy=0, done=0, result=0 immediately.
  - With MDU_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> second done at edge 1 with 2.
